// File: rtl/seg_to_score_decoder.sv
// Snoops a scanned, multiplexed active-low 7-seg bus and rebuilds the displayed
// BCD digits once a glyph has been seen unchanged for STABLE_CYCLES samples.
module seg_to_score_decoder #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic                    err
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STAB = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  state_t                st, st_nxt;
  logic [6:0]            seg_r, pat_q, pat_nxt;
  logic [NUM_DIGITS-1:0] an_r;
  logic [IW-1:0]         idx, idx_q, idx_nxt;
  logic [CW-1:0]         cnt_q, cnt_nxt, cnt_inc;
  logic                  legal, same, restart, cap;
  logic                  dec_ok, dec_blank, err_set;
  logic [3:0]            dec_val;
  logic [NUM_DIGITS-1:0] chg;
  int                    zc;

  // {ok, blank, value}
  function automatic logic [5:0] dec(input logic [6:0] p);
    case (p)
      7'b0000001: dec = {2'b10, 4'd0};
      7'b1001111: dec = {2'b10, 4'd1};
      7'b0010010: dec = {2'b10, 4'd2};
      7'b0000110: dec = {2'b10, 4'd3};
      7'b1001100: dec = {2'b10, 4'd4};
      7'b0100100: dec = {2'b10, 4'd5};
      7'b0100000: dec = {2'b10, 4'd6};
      7'b0001111: dec = {2'b10, 4'd7};
      7'b0000000: dec = {2'b10, 4'd8};
      7'b0001100: dec = {2'b10, 4'd9};
      7'b1111111: dec = {2'b01, 4'd0};
      default:    dec = {2'b00, 4'd0};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r <= '1;
      an_r  <= '1;
      st    <= IDLE;
      pat_q <= '1;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      seg_r <= seg_in;
      an_r  <= an_in;
      st    <= st_nxt;
      pat_q <= pat_nxt;
      idx_q <= idx_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // A sample is only meaningful when exactly one digit enable is active.
  always_comb begin
    idx = '0;
    zc  = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_r[i]) begin
        zc  = zc + 1;
        idx = IW'(i);
      end
    end
    legal = (zc == 1);
  end

  assign same    = (idx == idx_q) && (seg_r == pat_q);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    st_nxt  = st;
    pat_nxt = pat_q;
    idx_nxt = idx_q;
    cnt_nxt = cnt_q;
    cap     = 1'b0;
    restart = 1'b0;
    case (st)
      IDLE: restart = legal;
      SETTLE: begin
        if (!legal) begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end else if (same) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == STAB) begin
            cap    = 1'b1;
            st_nxt = LOCKED;
          end
        end else begin
          restart = 1'b1;
        end
      end
      LOCKED: begin
        if (!legal) begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end else if (!same) begin
          restart = 1'b1;
        end
      end
      default: st_nxt = IDLE;
    endcase
    if (restart) begin
      pat_nxt = seg_r;
      idx_nxt = idx;
      cnt_nxt = CW'(1);
      if (STAB == CW'(1)) begin
        cap    = 1'b1;
        st_nxt = LOCKED;
      end else begin
        st_nxt = SETTLE;
      end
    end
  end

  // pat_nxt/idx_nxt hold the captured glyph on both the counted and the first-sample path.
  assign {dec_ok, dec_blank, dec_val} = dec(pat_nxt);
  assign err_set = cap && !dec_ok && !dec_blank;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    logic hit;
    assign hit    = cap && (idx_nxt == IW'(k));
    assign chg[k] = hit && (dec_ok ? (!digit_valid[k] || score_bcd[4*k +: 4] != dec_val)
                                   : digit_valid[k]);
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        score_bcd[4*k +: 4] <= '0;
        digit_valid[k]      <= 1'b0;
      end else if (hit) begin
        if (dec_ok) score_bcd[4*k +: 4] <= dec_val;
        digit_valid[k] <= dec_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd <= 1'b0;
      err <= 1'b0;
    end else begin
      upd <= |chg;
      err <= err_set | (err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_seg_to_score_decoder.sv
// Directed bench for seg_to_score_decoder (NUM_DIGITS=2, STABLE_CYCLES=4).
module tb_seg_to_score_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h7f;
  logic [1:0] an_in = 2'b11;
  logic       err_clr = 1'b0;
  logic [7:0] score_bcd;
  logic [1:0] digit_valid;
  logic       upd, err;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  bit seen3 = 1'b0;

  seg_to_score_decoder #(.NUM_DIGITS(2), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in), .err_clr(err_clr),
    .score_bcd(score_bcd), .digit_valid(digit_valid), .upd(upd), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd === 1'b1) upd_cnt++;
    if (score_bcd[3:0] == 4'd3) seen3 = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    upd_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    step(2);
    chk("rst_score", score_bcd, 8'h00);
    chk("rst_valid", digit_valid, 2'b00);
    chk("rst_upd", upd, 1'b0);
    chk("rst_err", err, 1'b0);

    // reset mid-settle discards the partial count
    an_in = 2'b01; seg_in = 7'b0001111; rst_n = 1'b1;
    step(3);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    step(4);
    chk("midrst_nocap", digit_valid, 2'b00);
    step(1);
    chk("midrst_valid", digit_valid, 2'b10);
    chk("midrst_score", score_bcd, 8'h70);

    // single digit capture latency and upd pulse
    do_reset();
    an_in = 2'b10; seg_in = 7'b0010010;
    step(4);
    chk("t2_pre_valid", digit_valid, 2'b00);
    step(1);
    chk("t2_score", score_bcd, 8'h02);
    chk("t2_valid", digit_valid, 2'b01);
    chk("t2_upd", upd, 1'b1);
    step(1);
    chk("t2_upd_drop", upd, 1'b0);
    step(5);
    chk("t2_upd_cnt", upd_cnt, 1);

    // scanned two-digit display, repeated scan gives no extra upd
    do_reset();
    repeat (2) begin
      an_in = 2'b10; seg_in = 7'b1001100; step(6);
      an_in = 2'b01; seg_in = 7'b0000000; step(6);
    end
    chk("t3_score", score_bcd, 8'h84);
    chk("t3_valid", digit_valid, 2'b11);
    chk("t3_upd_cnt", upd_cnt, 2);

    // short glitch glyph never captured
    an_in = 2'b10; seg_in = 7'b0000110;
    step(3);
    seg_in = 7'b0100100;
    step(4);
    chk("t4_hold", score_bcd, 8'h84);
    step(1);
    chk("t4_score", score_bcd, 8'h85);
    step(3);
    chk("t4_no3", seen3, 1'b0);
    chk("t4_upd_cnt", upd_cnt, 3);

    // illegal glyph, err_clr, and err set beating err_clr
    seg_in = 7'b1111110;
    step(5);
    chk("t5_err", err, 1'b1);
    chk("t5_valid", digit_valid, 2'b10);
    chk("t5_score", score_bcd, 8'h85);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("t5_clr", err, 1'b0);
    seg_in = 7'b1111101;
    step(4);
    chk("t5_pre", err, 1'b0);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("t5_set_wins", err, 1'b1);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("t5_clr2", err, 1'b0);
    chk("t5_upd_cnt", upd_cnt, 4);

    // no-digit / multi-digit enables hold outputs
    an_in = 2'b00; step(10);
    an_in = 2'b11; step(10);
    chk("t6_score", score_bcd, 8'h85);
    chk("t6_valid", digit_valid, 2'b10);
    chk("t6_upd_cnt", upd_cnt, 4);

    // blank glyph clears valid without err, value kept
    an_in = 2'b01; seg_in = 7'b1111111;
    step(5);
    chk("t6_blank_valid", digit_valid, 2'b00);
    chk("t6_blank_err", err, 1'b0);
    chk("t6_blank_score", score_bcd, 8'h85);
    step(2);
    chk("t6_blank_upd_cnt", upd_cnt, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
